// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;
    localparam int          ILEN             = 32;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;
endpackage

// File: rtl/fetch_buf.sv
// In-order instruction queue: entries are allocated at request time and filled
// in order as responses return; only a filled head is visible to decode.
module fetch_buf
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             alloc,
    input  logic [ILEN-1:0]  alloc_pc,
    input  logic             fill,
    input  logic [ILEN-1:0]  fill_data,
    input  logic             pop,
    output logic             head_valid,
    output logic [ILEN-1:0]  head_pc,
    output logic [ILEN-1:0]  head_data,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] pend_cnt
);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [ILEN-1:0]  pc_q   [DEPTH];
    logic [ILEN-1:0]  data_q [DEPTH];
    logic [DEPTH-1:0] filled_q;
    logic [PTR_W-1:0] head_q, tail_q, fill_q;
    logic [CNT_W-1:0] count_q, pend_q;

    always_ff @(posedge clk) begin
        if (alloc) pc_q[tail_q] <= alloc_pc;
        if (fill)  data_q[fill_q] <= fill_data;
    end

    // Tail, fill and head slots never coincide when their strobes are active.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            head_q   <= '0;
            tail_q   <= '0;
            fill_q   <= '0;
            count_q  <= '0;
            pend_q   <= '0;
            filled_q <= '0;
        end else begin
            if (alloc) begin
                filled_q[tail_q] <= 1'b0;
                tail_q           <= tail_q + PTR_ONE;
            end
            if (fill) begin
                filled_q[fill_q] <= 1'b1;
                fill_q           <= fill_q + PTR_ONE;
            end
            if (pop) begin
                filled_q[head_q] <= 1'b0;
                head_q           <= head_q + PTR_ONE;
            end
            count_q <= count_q + CNT_W'(alloc) - CNT_W'(pop);
            pend_q  <= pend_q + CNT_W'(alloc) - CNT_W'(fill);
        end
    end

    assign head_valid = filled_q[head_q];
    assign head_pc    = pc_q[head_q];
    assign head_data  = data_q[head_q];
    assign count      = count_q;
    assign pend_cnt   = pend_q;
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, imem request/response, in-order queue and redirect.
// FETCH_MISALIGN_CHK_EN enables misaligned-redirect detection and the HALT state.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int          BUF_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [ILEN-1:0]  imem_req_addr,
    input  logic             imem_rsp_valid,
    input  logic [ILEN-1:0]  imem_rsp_data,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [ILEN-1:0]  instr,
    output logic [ILEN-1:0]  instr_pc,
    input  logic             redirect,
    input  logic [ILEN-1:0]  redirect_pc,
    output logic             misalign_err
);
    localparam int               PTR_W    = $clog2(BUF_DEPTH);
    localparam int               CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUF_DEPTH);

    fetch_state_t     state;
    logic [ILEN-1:0]  fetch_pc;
    logic [CNT_W-1:0] drop_cnt, count, pend_cnt, outstanding, drop_after;
    logic [ILEN-1:0]  head_pc, head_data, last_instr, last_pc, target_pc;
    logic             head_valid, accept, fill, pop, rsp_live, misaligned;

`ifdef FETCH_MISALIGN_CHK_EN
    logic misalign_q;

    assign misaligned = |redirect_pc[1:0];
    assign target_pc  = redirect_pc;

    always_ff @(posedge clk) begin
        if (!rst) misalign_q <= 1'b0;
        else      misalign_q <= redirect && misaligned;
    end
    assign misalign_err = misalign_q;
`else
    logic unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];
    assign misaligned          = 1'b0;
    assign target_pc           = {redirect_pc[ILEN-1:2], 2'b00};
    assign misalign_err        = 1'b0;
`endif

    assign imem_req_valid = rst && (state == FETCH) && !redirect && (count < FULL_CNT);
    assign imem_req_addr  = fetch_pc;
    assign accept         = imem_req_valid && imem_req_ready;

    // Live entries and drop_cnt are never both non-zero, so their sum is the
    // number of requests still owed a response.
    assign outstanding = pend_cnt + drop_cnt;
    assign rsp_live    = imem_rsp_valid && (outstanding != '0);
    assign drop_after  = outstanding - CNT_W'(rsp_live);
    assign fill        = rsp_live && (state == FETCH) && !redirect;
    assign pop         = instr_valid && instr_ready;

    assign instr_valid = head_valid;
    assign instr       = head_valid ? head_data : last_instr;
    assign instr_pc    = head_valid ? head_pc   : last_pc;

    fetch_buf #(.DEPTH(BUF_DEPTH)) u_buf (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect),
        .alloc      (accept),
        .alloc_pc   (fetch_pc),
        .fill       (fill),
        .fill_data  (imem_rsp_data),
        .pop        (pop),
        .head_valid (head_valid),
        .head_pc    (head_pc),
        .head_data  (head_data),
        .count      (count),
        .pend_cnt   (pend_cnt)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= FETCH;
            fetch_pc   <= RESET_PC;
            drop_cnt   <= '0;
            last_instr <= '0;
            last_pc    <= '0;
        end else begin
            if (head_valid) begin
                last_instr <= head_data;
                last_pc    <= head_pc;
            end
            if (redirect) begin
                fetch_pc <= target_pc;
                drop_cnt <= drop_after;
                if (misaligned)               state <= HALT;
                else if (drop_after == '0)    state <= FETCH;
                else                          state <= DRAIN;
            end else begin
                case (state)
                    FETCH: if (accept) fetch_pc <= fetch_pc + PC_STEP;
                    DRAIN: if (rsp_live) begin
                        drop_cnt <= drop_after;
                        if (drop_after == '0) state <= FETCH;
                    end
                    HALT:  if (rsp_live) drop_cnt <= drop_after;
                    default: state <= FETCH;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: memory model with programmable latency,
// scoreboard of expected (pc, word) pairs pushed on request acceptance.
module tb_instr_fetch;
    import fetch_pkg::*;

    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req_valid, imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = 32'h0;
    logic        instr_valid, instr_ready = 1'b0;
    logic [31:0] instr, instr_pc;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        misalign_err;

    int checks = 0, errors = 0;
    int accepts = 0, delivered = 0, cyc = 0, lat = 1;
    logic [31:0] exp_pc = RST_PC, last_del_pc = 32'h0;
    logic [63:0] sb[$];
    logic [63:0] sb_e;
    logic [31:0] acc_log[$];
    logic [31:0] mq_addr[$];
    int          mq_due[$];

    instr_fetch #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
        .redirect(redirect), .redirect_pc(redirect_pc), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a ^ 32'h1357_9BDF) + {a[15:0], a[31:16]};
    endfunction

    // Instruction memory: in-order responses, lat cycles after acceptance.
    always @(posedge clk) begin
        if (!rst) begin
            mq_addr.delete();
            mq_due.delete();
        end else begin
            if (imem_rsp_valid && mq_addr.size() != 0) begin
                void'(mq_addr.pop_front());
                void'(mq_due.pop_front());
            end
            if (imem_req_valid && imem_req_ready) begin
                mq_addr.push_back(imem_req_addr);
                mq_due.push_back(cyc + lat);
            end
        end
        cyc++;
        #1;
        if (mq_addr.size() != 0 && mq_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mq_addr[0]);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
    end

    // Request-address model and delivery scoreboard.
    always @(posedge clk) begin
        if (!rst) begin
            sb.delete();
            exp_pc = RST_PC;
        end else begin
            if (redirect) begin
                checks++;
                if (imem_req_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL req_during_redirect: valid=%b required 0", imem_req_valid);
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                checks++;
                if (imem_req_addr !== exp_pc) begin
                    errors++;
                    $display("FAIL req_addr: got %h required %h", imem_req_addr, exp_pc);
                end
                sb.push_back({exp_pc, mem_word(exp_pc)});
                acc_log.push_back(imem_req_addr);
                accepts++;
                exp_pc = exp_pc + 32'd4;
            end
            if (instr_valid && instr_ready) begin
                checks++;
                delivered++;
                last_del_pc = instr_pc;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_instr: pc=%h data=%h with empty scoreboard", instr_pc, instr);
                end else begin
                    sb_e = sb.pop_front();
                    if ({instr_pc, instr} !== sb_e) begin
                        errors++;
                        $display("FAIL instr_out: pc=%h data=%h required pc=%h data=%h",
                                 instr_pc, instr, sb_e[63:32], sb_e[31:0]);
                    end
                end
            end
            if (redirect) begin
                sb.delete();
`ifdef FETCH_MISALIGN_CHK_EN
                exp_pc = redirect_pc;
`else
                exp_pc = redirect_pc & 32'hFFFF_FFFC;
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++;
        if (imem_req_valid !== 1'b0 || imem_req_addr !== RST_PC || instr_valid !== 1'b0 ||
            instr !== 32'h0 || instr_pc !== 32'h0 || misalign_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: rv=%b ra=%h iv=%b i=%h ipc=%h me=%b required 0,%h,0,0,0,0",
                     imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc, misalign_err, RST_PC);
        end
        checks++;
        if (dut.state !== FETCH) begin
            errors++;
            $display("FAIL reset_state: got %0d required FETCH", dut.state);
        end
    endtask

    task automatic test_stream();
        int d0;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        lat            = 1;
        rst            = 1'b1;
        #1;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
            errors++;
            $display("FAIL first_req: valid=%b addr=%h required 1,%h", imem_req_valid, imem_req_addr, RST_PC);
        end
        tick();
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: instr_valid=%b required 0", instr_valid);
        end
        tick();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== RST_PC) begin
            errors++;
            $display("FAIL latency_first: instr_valid=%b pc=%h required 1,%h", instr_valid, instr_pc, RST_PC);
        end
        d0 = delivered;
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (instr_valid !== 1'b1) begin
                errors++;
                $display("FAIL throughput: instr_valid=0 at step %0d required 1", i);
            end
            tick();
        end
        checks++;
        if (delivered - d0 !== 20) begin
            errors++;
            $display("FAIL stream_count: delivered %0d required 20", delivered - d0);
        end
    endtask

    task automatic test_backpressure();
        int a0, d0;
        imem_req_ready = 1'b0;
        repeat (6) tick();
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_empty: instr_valid=%b required 0", instr_valid);
        end
        instr_ready    = 1'b0;
        imem_req_ready = 1'b1;
        a0 = accepts;
        repeat (10) tick();
        checks++;
        if (accepts - a0 !== DEPTH || imem_req_valid !== 1'b0 || instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_full: accepts=%0d rv=%b iv=%b required %0d,0,1",
                     accepts - a0, imem_req_valid, instr_valid, DEPTH);
        end
        d0 = delivered;
        instr_ready = 1'b1;
        repeat (12) tick();
        checks++;
        if (accepts - a0 <= DEPTH || delivered - d0 <= DEPTH) begin
            errors++;
            $display("FAIL bp_resume: accepts=%0d delivered=%0d required both > %0d",
                     accepts - a0, delivered - d0, DEPTH);
        end
    endtask

    task automatic test_redirect_drain();
        int a0, d0;
        bit seen;
        lat            = 3;
        imem_req_ready = 1'b0;
        repeat (8) tick();
        a0 = accepts;
        imem_req_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (accepts >= a0 + 2) break;
        end
        imem_req_ready = 1'b0;
        checks++;
        if (accepts - a0 !== 2) begin
            errors++;
            $display("FAIL drain_setup: accepts=%0d required 2", accepts - a0);
        end
        d0          = delivered;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        tick();
        redirect       = 1'b0;
        imem_req_ready = 1'b1;
        checks++;
        if (dut.state !== DRAIN || imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_state: state=%0d rv=%b required DRAIN,0", dut.state, imem_req_valid);
        end
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (imem_req_valid) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!seen || imem_req_addr !== 32'h0000_0100) begin
            errors++;
            $display("FAIL drain_restart: seen=%b addr=%h required 1,00000100", seen, imem_req_addr);
        end
        for (int i = 0; i < 20 && delivered == d0; i++) tick();
        checks++;
        if (delivered == d0 || last_del_pc !== 32'h0000_0100) begin
            errors++;
            $display("FAIL drain_first_pc: delivered=%0d pc=%h required >0,00000100", delivered - d0, last_del_pc);
        end
    endtask

    task automatic test_redirect_coincident();
        int d0;
        lat = 1;
        repeat (10) tick();
        checks++;
        if (instr_valid !== 1'b1 || imem_rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL coinc_setup: iv=%b rsp=%b required 1,1", instr_valid, imem_rsp_valid);
        end
        d0          = delivered;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0300;
        tick();
        redirect = 1'b0;
        checks++;
        if (delivered - d0 !== 1 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL coinc_flush: delivered=%0d iv=%b required 1,0", delivered - d0, instr_valid);
        end
        for (int i = 0; i < 10 && delivered == d0 + 1; i++) tick();
        checks++;
        if (last_del_pc !== 32'h0000_0300) begin
            errors++;
            $display("FAIL coinc_restart: pc=%h required 00000300", last_del_pc);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] want[3];
        want[0] = 32'hFFFF_FFF8;
        want[1] = 32'hFFFF_FFFC;
        want[2] = 32'h0000_0000;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        tick();
        redirect = 1'b0;
        acc_log.delete();
        for (int i = 0; i < 20 && acc_log.size() < 3; i++) tick();
        checks++;
        if (acc_log.size() < 3) begin
            errors++;
            $display("FAIL wrap_timeout: got %0d requests required 3", acc_log.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (acc_log[i] !== want[i]) begin
                    errors++;
                    $display("FAIL wrap_addr%0d: got %h required %h", i, acc_log[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_misalign();
        int a0;
        repeat (4) tick();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0102;
        tick();
        redirect = 1'b0;
        acc_log.delete();
`ifdef FETCH_MISALIGN_CHK_EN
        checks++;
        if (misalign_err !== 1'b1 || dut.state !== HALT) begin
            errors++;
            $display("FAIL misalign_pulse: err=%b state=%0d required 1,HALT", misalign_err, dut.state);
        end
        a0 = accepts;
        tick();
        checks++;
        if (misalign_err !== 1'b0) begin
            errors++;
            $display("FAIL misalign_width: err=%b required 0", misalign_err);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (imem_req_valid !== 1'b0) begin
                errors++;
                $display("FAIL halt_req: valid=%b required 0", imem_req_valid);
            end
            tick();
        end
        checks++;
        if (accepts !== a0) begin
            errors++;
            $display("FAIL halt_accepts: got %0d required 0", accepts - a0);
        end
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        tick();
        redirect = 1'b0;
        acc_log.delete();
        for (int i = 0; i < 10 && acc_log.size() == 0; i++) tick();
        checks++;
        if (acc_log.size() == 0 || acc_log[0] !== 32'h0000_0200 || misalign_err !== 1'b0) begin
            errors++;
            $display("FAIL halt_resume: n=%0d err=%b required addr 00000200, err 0", acc_log.size(), misalign_err);
        end
`else
        a0 = accepts;
        checks++;
        if (misalign_err !== 1'b0) begin
            errors++;
            $display("FAIL misalign_tied: err=%b required 0", misalign_err);
        end
        for (int i = 0; i < 10 && acc_log.size() == 0; i++) tick();
        checks++;
        if (acc_log.size() == 0 || acc_log[0] !== 32'h0000_0100 || accepts == a0) begin
            errors++;
            $display("FAIL misalign_forced: n=%0d required first addr 00000100", acc_log.size());
        end
        checks++;
        if (misalign_err !== 1'b0) begin
            errors++;
            $display("FAIL misalign_tied_late: err=%b required 0", misalign_err);
        end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_drain();
        test_redirect_coincident();
        test_wrap();
        test_misalign();
        repeat (4) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
